multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Parametrised multi-cycle control FSM for the RV32I core; replaces the single-cycle combinational decoder.
//  Sequences FETCH/DECODE/EXEC/MEM/WB, latches the instruction, and drives datapath selects one phase at a time.
//  Decodes the full RV32I base set (incl. LUI/AUIPC/JAL/JALR) and supports wait-stated imem/dmem via req/ready.
// PARAMETERS
//  XLEN     32  datapath width; imm is sign-extended to XLEN
//  NOP_INSN 32'h00000013  reset value of ir (addi x0,x0,0)
// PORTS
//  clk          in   1     clock, all state on rising edge
//  reset        in   1     asynchronous, active-low (0 = reset asserted)
//  imem_req     out  1     instruction fetch request
//  imem_ready   in   1     fetch data valid this cycle
//  imem_rdata   in   32    fetched instruction
//  dmem_req     out  1     data access request
//  dmem_ready   in   1     data access complete this cycle
//  dmem_fcn     out  1     1 = load, 0 = store
//  dmem_size    out  3     funct3 of load/store (byte/half/word, unsigned)
//  br_cond      in   1     branch comparator result for br_funct (1 = take)
//  ir           out  32    latched instruction
//  imm          out  XLEN  sign-extended immediate (I/S/B/U/J per opcode)
//  br_funct     out  3     branch funct3 to comparator
//  op1_sel      out  1     0 = rs1, 1 = pc
//  op2_sel      out  2     00 = rs2, 01 = imm, 10 = constant 4
//  alu_ctrl     out  4     0 AND,1 OR,2 ADD,3 SLL,4 XOR,5 SRL,6 SUB,7 SRA,8 SLT,9 SLTU,A COPY_B
//  pc_sel       out  2     00 = pc+imm, 01 = jalr (alu_out & ~1), 10 = pc+4
//  pc_wen       out  1     one-cycle pc update strobe
//  rf_wen       out  1     one-cycle register-file write strobe
//  wb_sel       out  2     00 = dmem, 01 = alu, 10 = pc+4
//  retire       out  1     one-cycle pulse when an instruction completes
//  illegal_insn out  1     sticky illegal-instruction flag
//  state        out  3     FSM state (0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP)
// BEHAVIOUR
//  Reset: state = FETCH, ir = NOP_INSN; all strobes, reqs and illegal_insn = 0; selects 0.
//  Reset assertion mid-access abandons the pending request at once; no partial commit.
//  FETCH: imem_req = 1 until imem_ready. ir captured on req & ready, then -> DECODE.
//    imem_rdata ignored otherwise.
//  DECODE: imm/alu_ctrl/selects settle from ir. Illegal -> TRAP, else -> EXEC.
//    Illegal: unknown opcode; load f3 3/6/7; store f3 > 2; branch f3 2/3; jalr f3 != 0;
//    R funct7 not 0/0x20, or 0x20 with f3 not 0/5; shift-imm funct7 invalid.
//  EXEC: ALU ops/LUI/AUIPC/JAL/JALR -> WB. Load/store -> MEM.
//    Branch: pc_wen = 1 and retire = 1; pc_sel = 00 if br_cond else 10; -> FETCH.
//  MEM: dmem_req = 1 until dmem_ready; dmem_fcn/dmem_size stable while req is high.
//    Load -> WB. Store: pc_wen, pc_sel = 10, retire on ready; -> FETCH.
//  WB: rf_wen = 1 unless rd = x0, pc_wen = 1, retire = 1, -> FETCH.
//    pc_sel: JAL 00, JALR 01, others 10. wb_sel: JAL/JALR 10, load 00, else 01.
//  Minimum latency with zero wait states: branch 3, ALU/jump/store 4, load 5 cycles.
//    Each wait cycle adds exactly 1.
//  LUI: op2 = imm, alu = COPY_B. AUIPC: op1 = pc, op2 = imm, ADD.
//    JAL/JALR WB: op1 = pc, op2 = 4, ADD.
//  TRAP: terminal until reset; illegal_insn = 1; no req/wen/retire.
//  Strobes never assert outside their state; rf_wen and pc_wen never coincide except in WB.
// CONFIGURATION
//  CTRL_PERF_CNT_EN defined: adds outputs cycle_cnt[63:0] (+1 every cycle out of reset)
//    and instret_cnt[63:0] (+1 per retire).
//    Both clear on reset, wrap modulo 2^64, freeze in TRAP.
//  Undefined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  - Reset, imem_rdata = 0x00500093 (addi x1,x0,5), ready immediate
//    -> FETCH/DECODE/EXEC/WB, rf_wen at cycle 4, alu_ctrl = 2, op2_sel = 01, imm = 5.
//  - lw 0x0040A103 with dmem_ready delayed 3 cycles
//    -> dmem_req held 4 cycles, dmem_fcn = 1, dmem_size = 2, wb_sel = 00, retire at cycle 8.
//  - beq 0xFE000EE3 with br_cond = 1 -> pc_wen in EXEC, pc_sel = 00, imm = -4, no rf_wen.
//    With br_cond = 0 -> pc_sel = 10.
//  - jalr 0x000080E7 -> WB with pc_sel = 01, wb_sel = 10, rf_wen = 1. lui x1 -> alu_ctrl = A.
//  - 0xFFFFFFFF -> TRAP, illegal_insn = 1, imem_req = 0 thereafter; reset low clears to FETCH.
//  - Reset asserted while dmem_req = 1 -> req drops same cycle, no retire.
//    With CTRL_PERF_CNT_EN, instret_cnt counts 3 after 3 retires.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with req/ready memories.
// Define CTRL_PERF_CNT_EN to add the cycle_cnt/instret_cnt performance counters.
module multicycle_control #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INSN = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    input  logic            dmem_ready,
    output logic            dmem_fcn,
    output logic [2:0]      dmem_size,
    input  logic            br_cond,
    output logic [31:0]     ir,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      br_funct,
    output logic            op1_sel,
    output logic [1:0]      op2_sel,
    output logic [3:0]      alu_ctrl,
    output logic [1:0]      pc_sel,
    output logic            pc_wen,
    output logic            rf_wen,
    output logic [1:0]      wb_sel,
    output logic            retire,
    output logic            illegal_insn,
`ifdef CTRL_PERF_CNT_EN
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt,
`endif
    output logic [2:0]      state
);

    typedef enum logic [2:0] {
        StFetch = 3'd0, StDecode = 3'd1, StExec = 3'd2, StMem = 3'd3, StWb = 3'd4, StTrap = 3'd7
    } state_e;

    typedef enum logic [3:0] {
        AluAnd = 4'h0, AluOr = 4'h1, AluAdd = 4'h2, AluSll = 4'h3, AluXor = 4'h4, AluSrl = 4'h5,
        AluSub = 4'h6, AluSra = 4'h7, AluSlt = 4'h8, AluSltu = 4'h9, AluCopyB = 4'ha
    } alu_e;

    localparam logic [6:0] OpLui = 7'h37, OpAuipc = 7'h17, OpJal = 7'h6f, OpJalr = 7'h67;
    localparam logic [6:0] OpBranch = 7'h63, OpLoad = 7'h03, OpStore = 7'h23, OpImm = 7'h13;
    localparam logic [6:0] OpReg = 7'h33, OpFence = 7'h0f, OpSystem = 7'h73;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;

    logic [6:0]  opcode, f7;
    logic [2:0]  f3;
    logic [31:0] imm32;
    alu_e        dec_alu;
    logic        dec_op1, dec_illegal;
    logic [1:0]  dec_op2;
    logic        is_load, is_store, is_branch, is_jal, is_jalr, is_misc;

    assign opcode    = ir_q[6:0];
    assign f3        = ir_q[14:12];
    assign f7        = ir_q[31:25];
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_branch = (opcode == OpBranch);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr);
    assign is_misc   = (opcode == OpFence) || (opcode == OpSystem);

    function automatic alu_e alu_from_f3(input logic [2:0] fn, input logic alt);
        alu_e a;
        a = AluAdd;
        unique case (fn)
            3'd0: a = alt ? AluSub : AluAdd;
            3'd1: a = AluSll;
            3'd2: a = AluSlt;
            3'd3: a = AluSltu;
            3'd4: a = AluXor;
            3'd5: a = alt ? AluSra : AluSrl;
            3'd6: a = AluOr;
            3'd7: a = AluAnd;
        endcase
        return a;
    endfunction

    always_comb begin
        imm32       = '0;
        dec_alu     = AluAdd;
        dec_op1     = 1'b0;
        dec_op2     = 2'b00;
        dec_illegal = 1'b0;
        unique case (opcode)
            OpLui: begin
                imm32   = {ir_q[31:12], 12'b0};
                dec_op2 = 2'b01;
                dec_alu = AluCopyB;
            end
            OpAuipc: begin
                imm32   = {ir_q[31:12], 12'b0};
                dec_op1 = 1'b1;
                dec_op2 = 2'b01;
            end
            OpJal: begin
                imm32   = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
                dec_op1 = 1'b1;
                dec_op2 = 2'b01;
            end
            OpJalr: begin
                imm32       = {{20{ir_q[31]}}, ir_q[31:20]};
                dec_op2     = 2'b01;
                dec_illegal = (f3 != 3'd0);
            end
            OpBranch: begin
                imm32       = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
                dec_illegal = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OpLoad: begin
                imm32       = {{20{ir_q[31]}}, ir_q[31:20]};
                dec_op2     = 2'b01;
                dec_illegal = (f3 == 3'd3) || (f3 >= 3'd6);
            end
            OpStore: begin
                imm32       = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
                dec_op2     = 2'b01;
                dec_illegal = (f3 > 3'd2);
            end
            OpImm: begin
                imm32       = {{20{ir_q[31]}}, ir_q[31:20]};
                dec_op2     = 2'b01;
                // Only shifts carry funct7; addi with imm[10] set must stay ADD.
                dec_alu     = alu_from_f3(f3, f7[5] && (f3 == 3'd5));
                dec_illegal = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                              ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
            end
            OpReg: begin
                dec_alu     = alu_from_f3(f3, f7[5]);
                dec_illegal = (f7 != 7'h00) &&
                              ((f7 != 7'h20) || ((f3 != 3'd0) && (f3 != 3'd5)));
            end
            OpFence, OpSystem: imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
            default: dec_illegal = 1'b1;
        endcase
    end

    assign imm          = XLEN'($signed(imm32));
    assign ir           = ir_q;
    assign state        = state_q;
    assign illegal_insn = (state_q == StTrap);

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_fcn  = 1'b0;
        dmem_size = 3'd0;
        pc_wen    = 1'b0;
        rf_wen    = 1'b0;
        retire    = 1'b0;
        alu_ctrl  = 4'd0;
        op1_sel   = 1'b0;
        op2_sel   = 2'b00;
        pc_sel    = 2'b00;
        wb_sel    = 2'b00;
        br_funct  = 3'd0;
        // Selects stay at zero in FETCH (and hence during reset) and in TRAP.
        if (state_q inside {StDecode, StExec, StMem, StWb}) begin
            alu_ctrl = dec_alu;
            op1_sel  = dec_op1;
            op2_sel  = dec_op2;
            br_funct = is_branch ? f3 : 3'd0;
            if (is_branch)    pc_sel = br_cond ? 2'b00 : 2'b10;
            else if (is_jal)  pc_sel = 2'b00;
            else if (is_jalr) pc_sel = 2'b01;
            else              pc_sel = 2'b10;
            if (is_jal || is_jalr) wb_sel = 2'b10;
            else if (is_load)      wb_sel = 2'b00;
            else                   wb_sel = 2'b01;
        end
        unique case (state_q)
            StFetch: begin
                imem_req = reset;
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = StDecode;
                end
            end
            StDecode: state_d = dec_illegal ? StTrap : StExec;
            StExec: begin
                if (is_branch) begin
                    pc_wen  = 1'b1;
                    retire  = 1'b1;
                    state_d = StFetch;
                end else if (is_load || is_store) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                dmem_req  = 1'b1;
                dmem_fcn  = is_load;
                dmem_size = f3;
                if (dmem_ready) begin
                    if (is_store) begin
                        pc_wen  = 1'b1;
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                rf_wen  = (ir_q[11:7] != 5'd0) && !is_misc;
                pc_wen  = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
                // Link value pc+4 is formed on the ALU during writeback.
                if (is_jal || is_jalr) begin
                    op1_sel  = 1'b1;
                    op2_sel  = 2'b10;
                    alu_ctrl = AluAdd;
                end
            end
            StTrap: state_d = StTrap;
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StFetch;
            ir_q    <= NOP_INSN;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

`ifdef CTRL_PERF_CNT_EN
    logic [63:0] cycle_cnt_q, instret_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else if (state_q != StTrap) begin
            cycle_cnt_q   <= cycle_cnt_q + 64'd1;
            instret_cnt_q <= instret_cnt_q + {63'd0, retire};
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`endif

endmodule
